// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

  // Counter just wide enough to hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell; outputs are forced low when not enabled.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  input  logic enable,
  output logic Diff,
  output logic Bout
);

  always_comb begin
    Diff = 1'b0;
    Bout = 1'b0;
    if (enable) begin
      Diff = A ^ B ^ Bin;
      Bout = (~A & B) | (~(A ^ B) & Bin);
    end
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, LSB first, one bit per enabled
// clock, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_br;
  logic [CntW-1:0]    r_cnt;
  logic               w_adv;
  logic               w_last;
  logic               w_d;
  logic               w_br_next;

  assign w_adv  = enable && (r_state == StRun);
  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  full_subtractor u_fs (
    .A      (r_a[0]),
    .B      (r_b[0]),
    .Bin    (r_br),
    .enable (w_adv),
    .Diff   (w_d),
    .Bout   (w_br_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (enable) begin
      case (r_state)
        StIdle:  if (start) w_state_next = StRun;
        StRun:   if (w_last) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (enable) begin
      if (r_state == StIdle && start) begin
        r_a   <= A;
        r_b   <= B;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == StRun) begin
        r_a   <= {1'b0, r_a[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_br  <= w_br_next;
        r_res <= {w_d, r_res[WIDTH-1:1]};
        r_cnt <= w_last ? '0 : r_cnt + CntW'(1);
        // Result registers only move on the completion edge.
        if (w_last) begin
          r_diff <= {w_d, r_res[WIDTH-1:1]};
          r_bout <= w_br_next;
        end
      end
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor that computes Diff = A - B and a borrow-out, LSB first, one bit per clock.
- Built around one full_subtractor cell plus a borrow flip-flop; it is the subtract-side counterpart to the full_adder cell.
- Serves the area-lean mantissa-difference path of the floating-point adder.
- Uses a start/busy/done handshake so a sequencer can issue one operation at a time.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  global advance enable; low freezes all state.
- start  input  1  request a new operation; honoured only in IDLE with enable=1.
- A  input  WIDTH  minuend, sampled on the accepting edge.
- B  input  WIDTH  subtrahend, sampled on the accepting edge.
- Diff  output  WIDTH  registered result (A - B) mod 2^WIDTH.
- Bout  output  1  registered final borrow; 1 iff A < B unsigned.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at an edge: state=IDLE, Diff=0, Bout=0, busy=0, done=0, shift registers=0, borrow=0, bit counter=0. rst overrides enable and start.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - At an edge where start=1 and enable=1 (call it edge E0): latch A and B into shift registers, clear borrow and counter, go to RUN.
  - busy=1 from E0.
- RUN:
  - Each edge with enable=1 processes one bit position:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the internal result register; the operand registers shift right; the counter increments.
  - Bit i is processed at edge E(i+1).
  - At edge E(WIDTH) the last bit is processed. On that edge: Diff <= full result, Bout <= br_next, busy <= 0, done <= 1, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - On the next enabled edge go to IDLE and set done=0.
  - start is not accepted in DONE.
- Latency: WIDTH clocks from the accepting edge to done, with enable held high.
- enable=0 in any state: no state, counter, shift or output change; done holds its value. Each disabled cycle delays completion by exactly one cycle.
- start while RUN or DONE: ignored. The in-flight operation and the values latched at E0 are unaffected by later changes on A and B.
- Diff and Bout change only on the completion edge or on reset. They hold the last result through IDLE and the next RUN.
- Counter width is $clog2(WIDTH). Completion is detected at count == WIDTH-1 on an enabled RUN edge, so there is no wrap-around.
- rst mid-RUN: the operation is aborted with no done pulse. The next start behaves as from power-up.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the counter-width localparam, derived via $clog2(WIDTH).
- One natural sub-module: full_subtractor.
  - Combinational, with ports A, B, Bin, Diff, Bout, enable.
  - Outputs are 0 when enable=0, matching full_adder.
  - Instantiated once, with enable tied to the RUN-state advance.

Test Plan (WIDTH=32):
- Basic subtract: A=10, B=3, start pulse, enable=1.
  - done high exactly 32 cycles after the accepting edge.
  - Diff=0x00000007, Bout=0.
  - busy high for 32 cycles.
- Negative result: A=3, B=10 -> Diff=0xFFFFFFF9, Bout=1.
- Full borrow chain and equal operands:
  - A=0, B=1 -> Diff=0xFFFFFFFF, Bout=1.
  - A=B=0x80000000 -> Diff=0, Bout=0.
- Enable stall: A=0x12345678, B=0x00000FFF, enable=0 for 5 cycles after bit 7.
  - done arrives 37 cycles after start.
  - Diff=0x12344679, Bout=0.
  - No output change during the stall.
- Start while busy: second start with A=1, B=1 pulsed at bit 4 of an operation with A=100, B=1 -> ignored; result Diff=99, Bout=0, exactly one done pulse.
- Reset mid-run: rst=1 at bit 10 of an operation with A=50, B=8.
  - Next cycle: busy=0, done=0, Diff=0, Bout=0.
  - A fresh start with A=50, B=8 yields Diff=42, Bout=0 after 32 cycles.
